// File: rtl/adder_acc_ctrl.sv
// Streaming accumulator controller around a ripple-carry adderN; sums len operands and reports sum plus carry count.
// Optional build macro: ADDER_ACC_SAT_EN clamps the accumulator at all-ones on any carry-out instead of wrapping.

module adderN #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

module adder_acc_ctrl #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_carry_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc;
    logic [CNT_W-1:0]   carry_cnt;
    logic [LEN_W-1:0]   remaining;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH-1:0]   acc_next;
    logic               xfer;

    adderN #(.WIDTH(WIDTH)) u_adder (
        .a    (acc),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign xfer = in_valid && in_ready;

`ifdef ADDER_ACC_SAT_EN
    assign acc_next = add_cout ? '1 : add_sum;
`else
    assign acc_next = add_sum;
`endif

    always_comb begin
        state_d       = state_q;
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        busy          = 1'b0;
        out_sum       = acc;
        out_carry_cnt = carry_cnt;
        case (state_q)
            IDLE: begin
                if (start) state_d = (len != '0) ? ACCUM : DONE;
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (xfer && remaining == LEN_W'(1)) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc       <= '0;
            carry_cnt <= '0;
            remaining <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc       <= '0;
                        carry_cnt <= '0;
                        if (len != '0) remaining <= len;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        acc       <= acc_next;
                        remaining <= remaining - LEN_W'(1);
                        // Counter sticks at all-ones once saturated.
                        if (add_cout && carry_cnt != '1) carry_cnt <= carry_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/adder_acc_ctrl.md
# adder_acc_ctrl

Streaming accumulator controller directly downstream of the `adderN` ripple-carry adder. It owns the accumulator register, feeds `acc` and each incoming operand into one `adderN` instance, and captures that instance's `sum` and `cout` every accepted beat. It sums a programmed number of WIDTH-bit operands arriving over a valid/ready stream. It then presents the registered total and a carry-out count on a valid/ready result port.

## Interface
- `WIDTH`, 8: operand/accumulator width; passed to the internal `adderN #(.WIDTH(WIDTH))`; must be at least 2.
- `LEN_W`, 8: width of the operand-count input.
- `CNT_W`, 4: width of the carry-out counter.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request to begin a job; sampled only in IDLE.
- `len` input LEN_W: number of operands in the job; sampled together with `start`.
- `in_valid` input 1: operand beat valid.
- `in_data` input WIDTH: operand.
- `in_ready` output 1: operand accepted when `in_valid && in_ready`.
- `out_valid` output 1: result valid.
- `out_ready` input 1: result consumed when `out_valid && out_ready`.
- `out_sum` output WIDTH: registered accumulated sum.
- `out_carry_cnt` output CNT_W: number of beats whose `adderN` `cout` was 1; saturates at all-ones.
- `busy` output 1: high in ACCUM and DONE.

## Operation
- The `adderN` instance has `a=acc`, `b=in_data`, and `cin=1'b0`. Its `sum` and `cout` are used only on accepted beats.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - `in_ready=0`, `out_valid=0`, `busy=0`.
  - On `start=1` with `len!=0`: `acc<=0`, `carry_cnt<=0`, `remaining<=len`, go to ACCUM.
  - On `start=1` with `len==0`: `acc<=0`, `carry_cnt<=0`, go directly to DONE.
- ACCUM:
  - `in_ready=1`.
  - On each transfer: `acc<=adderN.sum`. If `cout` is 1, `carry_cnt<=carry_cnt+1`; the counter holds at all-ones. Then `remaining<=remaining-1`.
  - A transfer with `remaining==1` moves the FSM to DONE.
  - No transfer: all state holds.
- DONE:
  - `out_valid=1`, `in_ready=0`.
  - `out_sum=acc` and `out_carry_cnt=carry_cnt`, both stable until the handshake.
  - On `out_valid && out_ready`: go to IDLE.
- `start` is ignored in ACCUM and DONE. `in_valid` is ignored outside ACCUM.
- `out_sum` and `out_carry_cnt` are driven from registers; they are not a combinational path from `in_data`.

## Timing
- Reset values: state=IDLE, `acc=0`, `carry_cnt=0`, `remaining=0`. Outputs: `in_ready=0`, `out_valid=0`, `busy=0`, `out_sum=0`, `out_carry_cnt=0`.
- `reset` asserted mid-job: the next cycle is IDLE with every register at its reset value. Partial results are discarded, and no `out_valid` is produced for the aborted job.
- `start` at edge N:
  - `busy` and `in_ready` are high from cycle N+1.
  - With `len==0`, `out_valid` is high from cycle N+1.
- Throughput: one operand per cycle while `in_valid` is held high.
- Last operand accepted at edge M: `out_valid=1` from cycle M+1, and `in_ready=0` in the same cycle.
- Result handshake at edge K: `out_valid=0` and `busy=0` at K+1. A new `start` is accepted at the earliest at edge K+1.
- Arithmetic: modulo 2^WIDTH (unless the macro below is defined). `cout` is counted per beat and never folded into `out_sum`.

## Configuration
- `ADDER_ACC_SAT_EN` defined: on any beat with `cout=1`, `acc<={WIDTH{1'b1}}`, so the sum clamps at the maximum. `carry_cnt` still increments normally.
- `ADDER_ACC_SAT_EN` undefined: `acc<=adderN.sum`, so the sum wraps.

## Test plan
- len=3, beats 10, 20, 30 back-to-back -> `out_sum=60`, `out_carry_cnt=0`, `out_valid` high the cycle after the third beat.
- len=2, beats 200, 100 -> `out_sum=44`, `out_carry_cnt=1`. With `ADDER_ACC_SAT_EN`: `out_sum=255`, `out_carry_cnt=1`.
- len=4, all beats 255 -> `out_sum=252`, `out_carry_cnt=3`. With `ADDER_ACC_SAT_EN`: `out_sum=255`, `out_carry_cnt=3`.
- len=0 start -> `out_valid=1`, `out_sum=0`, `out_carry_cnt=0` one cycle after `start`, and `in_ready` never rises.
- len=2, beats 5, 9 with 3 idle cycles between them, then `out_ready` held low 5 cycles while `start` pulses -> `out_sum=14` holds stable, `start` is ignored, `in_ready=0`, and the FSM returns to IDLE the cycle after `out_ready=1`.
- len=4, reset after 1 beat (value 50) -> all outputs 0 the next cycle. Then len=1, beat 7 -> `out_sum=7`, `out_carry_cnt=0`.
